// File: rtl/angle_reduce.sv
// Reduces an unsigned degree angle modulo 360 by shift-subtract, then folds it
// into a first-quadrant angle plus quadrant code for the sine LUT.
module angle_reduce #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] angle_in,
    output logic                  busy,
    output logic                  en_sine,
    output logic [1:0]            quadrant,
    output logic [DATA_WIDTH-1:0] angle_out
);

    localparam int unsigned K_MAX = DATA_WIDTH - 9;
    localparam int unsigned KW    = $clog2(K_MAX + 1);
    localparam int unsigned EW    = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        FOLD
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] r, r_next;
    logic [KW-1:0]         k, k_next;
    logic [1:0]            quad_next;
    logic [DATA_WIDTH-1:0] angle_next;
    logic                  en_next;
    logic                  busy_next;
    logic [EW-1:0]         modulus;
    logic [EW-1:0]         r_ext;

    // One extra bit so 360<<K_MAX never wraps.
    assign r_ext   = {1'b0, r};
    assign modulus = EW'(360) << k;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            r         <= '0;
            k         <= '0;
            quadrant  <= 2'd0;
            angle_out <= '0;
            en_sine   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            r         <= r_next;
            k         <= k_next;
            quadrant  <= quad_next;
            angle_out <= angle_next;
            en_sine   <= en_next;
            busy      <= busy_next;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next = state;
        r_next     = r;
        k_next     = k;
        quad_next  = quadrant;
        angle_next = angle_out;
        en_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    r_next     = angle_in;
                    k_next     = KW'(K_MAX);
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
                if (r_ext >= modulus) begin
                    r_next = DATA_WIDTH'(r_ext - modulus);
                end
                if (k == '0) begin
                    state_next = FOLD;
                end else begin
                    k_next = k - KW'(1);
                end
            end
            FOLD: begin
                // r is 0..359 here
                if (r <= DATA_WIDTH'(90)) begin
                    quad_next  = 2'd0;
                    angle_next = r;
                end else if (r <= DATA_WIDTH'(180)) begin
                    quad_next  = 2'd1;
                    angle_next = DATA_WIDTH'(180) - r;
                end else if (r <= DATA_WIDTH'(270)) begin
                    quad_next  = 2'd2;
                    angle_next = r - DATA_WIDTH'(180);
                end else begin
                    quad_next  = 2'd3;
                    angle_next = DATA_WIDTH'(360) - r;
                end
                en_next    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_angle_reduce.sv
// Directed bench for angle_reduce: vector table plus back-to-back, busy-start
// and asynchronous-reset sequences.
module tb_angle_reduce;

    localparam int unsigned DW      = 32;
    localparam int          LATENCY = 25;
    localparam int          LIMIT   = 40;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] angle_in;
    logic          busy;
    logic          en_sine;
    logic [1:0]    quadrant;
    logic [DW-1:0] angle_out;

    int errors = 0;
    int checks = 0;

    angle_reduce #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .angle_in (angle_in),
        .busy     (busy),
        .en_sine  (en_sine),
        .quadrant (quadrant),
        .angle_out(angle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] angle;
        logic [1:0]    q;
        logic [DW-1:0] a;
    } vec_t;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Launch a job: start is sampled at the next rising edge (E0).
    task automatic start_job(input logic [DW-1:0] a);
        @(negedge clk);
        start    = 1'b1;
        angle_in = a;
        @(posedge clk);
        #1;
        start    = 1'b0;
        angle_in = 32'h1234_5678;
    endtask

    // Count edges until en_sine; optionally pulse start with a decoy angle at edge 'poke'.
    task automatic wait_en(input int poke, input logic [DW-1:0] decoy, output int n);
        n = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            #1;
            if (i == poke) begin
                start    = 1'b1;
                angle_in = decoy;
            end else begin
                start = 1'b0;
            end
            if (en_sine) begin
                n = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string name, input int n, input logic [1:0] q,
                                input logic [DW-1:0] a);
        check({name, " latency"}, n, LATENCY);
        check({name, " quadrant"}, quadrant, q);
        check({name, " angle_out"}, angle_out, a);
    endtask

    task automatic check_width(input string name);
        @(posedge clk);
        #1;
        check({name, " en_sine width"}, en_sine, 0);
    endtask

    vec_t vecs[13];
    int   n;

    initial begin
        vecs[0]  = '{32'd30,         2'd0, 32'd30};
        vecs[1]  = '{32'd150,        2'd1, 32'd30};
        vecs[2]  = '{32'd210,        2'd2, 32'd30};
        vecs[3]  = '{32'd330,        2'd3, 32'd30};
        vecs[4]  = '{32'd0,          2'd0, 32'd0};
        vecs[5]  = '{32'd90,         2'd0, 32'd90};
        vecs[6]  = '{32'd180,        2'd1, 32'd0};
        vecs[7]  = '{32'd270,        2'd2, 32'd90};
        vecs[8]  = '{32'd359,        2'd3, 32'd1};
        vecs[9]  = '{32'd360,        2'd0, 32'd0};
        vecs[10] = '{32'd765,        2'd0, 32'd45};
        vecs[11] = '{32'hFFFF_FFFF,  2'd2, 32'd75};
        vecs[12] = '{32'd3019898880, 2'd0, 32'd0};

        reset_n  = 1'b0;
        start    = 1'b0;
        angle_in = '0;
        #12;
        check("reset busy", busy, 0);
        check("reset en_sine", en_sine, 0);
        check("reset quadrant", quadrant, 0);
        check("reset angle_out", angle_out, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            start_job(vecs[i].angle);
            check($sformatf("vec%0d busy", i), busy, 1);
            wait_en(0, '0, n);
            check_result($sformatf("vec%0d", i), n, vecs[i].q, vecs[i].a);
            check_width($sformatf("vec%0d", i));
        end

        // Back-to-back: start in the en_sine cycle, then a decoy start while busy
        start_job(32'd150);
        wait_en(0, '0, n);
        check_result("b2b first", n, 2'd1, 32'd30);
        start    = 1'b1;
        angle_in = 32'd330;
        @(posedge clk);
        #1;
        start    = 1'b0;
        angle_in = 32'd30;
        check("b2b accepted busy", busy, 1);
        wait_en(5, 32'd30, n);
        check_result("b2b second", n, 2'd3, 32'd30);
        check_width("b2b second");

        // Asynchronous reset mid-REDUCE: outputs clear without a clock edge
        start_job(32'd200);
        repeat (10) @(posedge clk);
        #2;
        check("pre-reset quadrant", quadrant, 3);
        reset_n = 1'b0;
        #1;
        check("async busy", busy, 0);
        check("async en_sine", en_sine, 0);
        check("async quadrant", quadrant, 0);
        check("async angle_out", angle_out, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        begin
            int seen = 0;
            repeat (LATENCY + 5) begin
                @(posedge clk);
                #1;
                if (en_sine) seen++;
            end
            check("no en_sine after reset", seen, 0);
        end
        start_job(32'd210);
        wait_en(0, '0, n);
        check_result("post-reset", n, 2'd2, 32'd30);
        check_width("post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
